// File: rtl/bf_prog_loader.sv
// bf_prog_loader: Brainfuck program loader.
// Accepts ASCII program bytes, encodes each command to a 3-bit opcode and
// writes it to program RAM at consecutive addresses from 0. A 0x00 byte ends
// the program. Comment bytes are accepted and dropped.
// Optional feature macro: BF_BRACKET_CHECK_EN. When it is defined, a bracket
// depth counter detects unbalanced or over-nested brackets. When it is not
// defined, '[' and ']' are written like any other opcode and err_bracket is 0.
// Handshake: a byte is taken on a rising clock edge when in_valid and
// in_ready are both high. in_ready depends only on the loader state and never
// on in_valid. The source holds in_data stable while in_valid is high and
// in_ready is low.
// The current state is kept in the register `state`, which can be observed
// hierarchically.
module bf_prog_loader #(
  parameter int ADDR_W = 8,
  parameter int NEST_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2:0]        wr_code,
  output logic [ADDR_W:0]   prog_len,
  output logic              busy,
  output logic              done,
  output logic              err_overflow,
  output logic              err_bracket
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [2:0] OP_OPEN  = 3'b011;
  localparam logic [2:0] OP_CLOSE = 3'b010;
  // prog_len value meaning the store is full (DEPTH = 2**ADDR_W).
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  state_t              state, state_d;
  logic [ADDR_W:0]     prog_len_d;
  logic                wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_d;
  logic [2:0]          wr_code_d;
  logic                err_ov_d;
  logic                accept;
  logic                is_op;
  logic [2:0]          op;
  logic                do_write;

`ifdef BF_BRACKET_CHECK_EN
  localparam logic [NEST_W-1:0] MAX_DEPTH = '1;
  logic [NEST_W-1:0]   depth, depth_d;
  logic                err_br_d;
`endif

  // in_ready is a register that is high exactly in LOAD, so accept is clean.
  assign accept = in_valid & in_ready;

  // Map an ASCII command byte to its opcode. Any other byte is not an opcode.
  always_comb begin
    is_op = 1'b1;
    op    = 3'b000;
    case (in_data)
      8'h2B:   op = 3'b111; // +
      8'h2D:   op = 3'b110; // -
      8'h3E:   op = 3'b101; // >
      8'h3C:   op = 3'b100; // <
      8'h5B:   op = 3'b011; // [
      8'h5D:   op = 3'b010; // ]
      8'h2E:   op = 3'b001; // .
      8'h2C:   op = 3'b000; // ,
      default: is_op = 1'b0;
    endcase
  end

  // Next-state logic and next values of all registered outputs.
  always_comb begin
    state_d    = state;
    prog_len_d = prog_len;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr;
    wr_code_d  = wr_code;
    err_ov_d   = err_overflow;
    do_write   = 1'b0;
`ifdef BF_BRACKET_CHECK_EN
    depth_d    = depth;
    err_br_d   = err_bracket;
`endif
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d    = LOAD;
          prog_len_d = '0;
          err_ov_d   = 1'b0;
`ifdef BF_BRACKET_CHECK_EN
          depth_d    = '0;
          err_br_d   = 1'b0;
`endif
        end
      end
      LOAD: begin
        // start is ignored here. Only the incoming byte can change the state.
        if (accept) begin
          if (in_data == 8'h00) begin
`ifdef BF_BRACKET_CHECK_EN
            if (depth != '0) begin
              err_br_d = 1'b1;
              state_d  = ERR;
            end else begin
              state_d  = DONE;
            end
`else
            state_d = DONE;
`endif
          end else if (is_op) begin
            // When the store is full, overflow takes priority over bracket checks.
            if (prog_len == FULL) begin
              err_ov_d = 1'b1;
              state_d  = ERR;
            end else begin
              do_write = 1'b1;
`ifdef BF_BRACKET_CHECK_EN
              if (op == OP_OPEN) begin
                if (depth == MAX_DEPTH) begin
                  do_write = 1'b0;
                  err_br_d = 1'b1;
                  state_d  = ERR;
                end else begin
                  depth_d = depth + 1'b1;
                end
              end else if (op == OP_CLOSE) begin
                if (depth == '0) begin
                  do_write = 1'b0;
                  err_br_d = 1'b1;
                  state_d  = ERR;
                end else begin
                  depth_d = depth - 1'b1;
                end
              end
`endif
            end
            if (do_write) begin
              wr_en_d    = 1'b1;
              wr_addr_d  = prog_len[ADDR_W-1:0];
              wr_code_d  = op;
              prog_len_d = prog_len + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers. Status flags are taken from the next state,
  // so every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_code      <= '0;
      prog_len     <= '0;
      err_overflow <= 1'b0;
    end else begin
      state        <= state_d;
      in_ready     <= (state_d == LOAD);
      busy         <= (state_d == LOAD);
      done         <= (state_d == DONE);
      wr_en        <= wr_en_d;
      wr_addr      <= wr_addr_d;
      wr_code      <= wr_code_d;
      prog_len     <= prog_len_d;
      err_overflow <= err_ov_d;
    end
  end

`ifdef BF_BRACKET_CHECK_EN
  // Bracket nesting depth and the sticky bracket error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth       <= '0;
      err_bracket <= 1'b0;
    end else begin
      depth       <= depth_d;
      err_bracket <= err_br_d;
    end
  end
`else
  assign err_bracket = 1'b0;
`endif

endmodule

// File: tb/tb_bf_prog_loader.sv
// Testbench for bf_prog_loader. The design is built with ADDR_W=4 (DEPTH=16)
// and NEST_W=2 (maximum nesting 3), so the overflow and nesting limits are
// reached quickly. Expected writes come from a byte-level program model.
module tb_bf_prog_loader;

  localparam int ADDR_W = 4;
  localparam int NEST_W = 2;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int MAXD   = (1 << NEST_W) - 1;
  localparam int W      = ADDR_W + 3;
`ifdef BF_BRACKET_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        wr_code;
  logic [ADDR_W:0]   prog_len;
  logic              busy;
  logic              done;
  logic              err_overflow;
  logic              err_bracket;

  bf_prog_loader #(.ADDR_W(ADDR_W), .NEST_W(NEST_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_code(wr_code), .prog_len(prog_len), .busy(busy), .done(done),
    .err_overflow(err_overflow), .err_bracket(err_bracket)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]   prog_q[$];

  // Model of one load: opcodes written, nesting depth, flags, and the end
  // status (0 = still loading, 1 = program complete, 2 = error).
  int m_len;
  int m_depth;
  bit m_ov;
  bit m_br;
  int m_fin;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int code_of(input logic [7:0] b);
    case (b)
      "+":     return 7;
      "-":     return 6;
      ">":     return 5;
      "<":     return 4;
      "[":     return 3;
      "]":     return 2;
      ".":     return 1;
      ",":     return 0;
      default: return -1;
    endcase
  endfunction

  // Monitor: every write strobe must match the next expected (addr, code).
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && wr_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d code %0d, expected no write", wr_addr, wr_code);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr_code", {wr_addr, wr_code}, e);
      end
    end
  end

  task automatic set_prog(input string s, input bit term);
    prog_q.delete();
    for (int i = 0; i < s.len(); i++) prog_q.push_back(s[i]);
    if (term) prog_q.push_back(8'h00);
  endtask

  task automatic model_byte(input logic [7:0] b);
    int c;
    c = code_of(b);
    if (b == 8'h00) begin
      if (CHK && m_depth != 0) begin m_br = 1'b1; m_fin = 2; end
      else m_fin = 1;
    end else if (c >= 0) begin
      if (m_len == DEPTH) begin
        m_ov = 1'b1; m_fin = 2;
      end else if (CHK && b == "[" && m_depth == MAXD) begin
        m_br = 1'b1; m_fin = 2;
      end else if (CHK && b == "]" && m_depth == 0) begin
        m_br = 1'b1; m_fin = 2;
      end else begin
        exp_q.push_back({m_len[ADDR_W-1:0], 3'(c)});
        m_len++;
        if (b == "[") m_depth++;
        if (b == "]") m_depth--;
      end
    end
  endtask

  // Driver tasks are called #1 after a rising edge.
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_len = 0; m_depth = 0; m_ov = 1'b0; m_br = 1'b0; m_fin = 0;
    check("busy_after_start", busy, 1);
    check("done_after_start", done, 0);
    check("in_ready_after_start", in_ready, 1);
    check("prog_len_after_start", prog_len, 0);
    check("err_overflow_after_start", err_overflow, 0);
    check("err_bracket_after_start", err_bracket, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin @(posedge clk); #1; end
    check("in_ready_loading", in_ready, 1);
    in_valid = 1'b1;
    in_data  = b;
    start    = ($urandom_range(0, 3) == 0);
    model_byte(b);
    @(posedge clk); #1;
    in_valid = 1'b0;
    start    = 1'b0;
    in_data  = 8'($urandom_range(0, 255));
  endtask

  task automatic run_load(input int gapmax);
    do_start();
    foreach (prog_q[i]) begin
      if (m_fin != 0) break;
      send_byte(prog_q[i], $urandom_range(0, gapmax));
    end
    @(negedge clk);
    check("prog_len_end", prog_len, m_len);
    check("done_end", done, m_fin == 1);
    check("busy_end", busy, m_fin == 0);
    check("in_ready_end", in_ready, m_fin == 0);
    check("err_overflow_end", err_overflow, m_ov);
    check("err_bracket_end", err_bracket, m_br);
    check("pending_writes", exp_q.size(), 0);
    if (m_fin == 2) begin
      // Bytes offered in ERR must not be taken.
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = "+";
      repeat (2) @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("prog_len_held_err", prog_len, m_len);
      check("err_overflow_held", err_overflow, m_ov);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_code"}, wr_code, 0);
    check({tag, "_prog_len"}, prog_len, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err_overflow"}, err_overflow, 0);
    check({tag, "_err_bracket"}, err_bracket, 0);
  endtask

  // Main sequence: reset, directed programs, mid-load reset, random programs.
  initial begin
    string alpha;
    int    n;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #12;
    check_reset_values("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    set_prog("++.", 1'b1);          run_load(2);
    set_prog("+a b\n-", 1'b1);      run_load(2);
    set_prog("+[>+<-].", 1'b1);     run_load(0);
    prog_q.delete();
    for (int i = 0; i < DEPTH + 1; i++) prog_q.push_back("+");
    prog_q.push_back(8'h00);
    run_load(0);
    set_prog("]", 1'b1);            run_load(1);
    set_prog("[[+]", 1'b1);         run_load(1);
    set_prog("[[[]]]", 1'b1);       run_load(0);
    set_prog("[[[[]]]]", 1'b1);     run_load(0);
    set_prog("", 1'b1);             run_load(0);

    // Reset in the middle of a load: outputs return to reset values at once.
    do_start();
    send_byte("+", 0);
    send_byte("+", 0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #2;
    check_reset_values("midload_reset");
    check("writes_before_reset", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    set_prog("-", 1'b1);            run_load(0);

    // Random programs over commands, comments and brackets.
    alpha = "+-><[].,a \n#";
    for (int t = 0; t < 40; t++) begin
      prog_q.delete();
      n = $urandom_range(0, 22);
      for (int i = 0; i < n; i++) begin
        if (t % 2 == 0) prog_q.push_back(alpha[$urandom_range(0, 11)]);
        else begin
          logic [7:0] ch;
          ch = alpha[$urandom_range(0, 11)];
          if (ch == "[" || ch == "]") ch = ".";
          prog_q.push_back(ch);
        end
      end
      prog_q.push_back(8'h00);
      run_load($urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
